// File: rtl/simmem_pkg.sv
// simmem_pkg: shared types and constants for the simulated memory write path
package simmem_pkg;
  localparam int IdWidth = 4;
  localparam int AxLenWidth = 4;
  localparam int AddrWidth = 16;
  localparam int DataWidth = 32;
  localparam int WRespPayloadWidth = 4;
  localparam int WRespAddrQueueDepth = 4;
  localparam logic [AxLenWidth-1:0] MaxWBurstLen = 4'd4;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} xresp_e;
  typedef enum logic [1:0] {IDLE, DATA, RESP} wresp_state_e;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [AddrWidth-1:0] addr;
    logic [AxLenWidth-1:0] burst_len;
  } waddr_t;
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [DataWidth/8-1:0] strb;
    logic last;
  } wdata_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [WRespPayloadWidth-1:0] payload;
  } wresp_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [AxLenWidth-1:0] burst_len;
  } waddr_entry_t;
endpackage

// File: rtl/simmem_addr_fifo.sv
// simmem_addr_fifo: synchronous FIFO, extra pointer bit distinguishes full from empty
module simmem_addr_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PtrWidth = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [PtrWidth:0] wptr_q, rptr_q;
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q ^ rptr_q) == {1'b1, {PtrWidth{1'b0}}};
  assign rdata = mem[rptr_q[PtrWidth-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (push && !full) mem[wptr_q[PtrWidth-1:0]] <= wdata;
endmodule

// File: rtl/simmem_write_responder.sv
// simmem_write_responder: consumes write bursts and answers each buffered address in order
module simmem_write_responder
  import simmem_pkg::*;
#(
  parameter int AddrQueueDepth = WRespAddrQueueDepth
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  waddr_t waddr_i,
  input  logic   waddr_in_valid_i,
  output logic   waddr_in_ready_o,
  input  wdata_t wdata_i,
  input  logic   wdata_in_valid_i,
  output logic   wdata_in_ready_o,
  output wresp_t wrsp_o,
  output logic   wrsp_out_valid_o,
  input  logic   wrsp_out_ready_i
);
  wresp_state_e state_q, state_d;
  waddr_entry_t entry, head;
  wresp_t rsp;
  logic full, empty, push, pop, beat, final_beat, err_q;
  logic [AxLenWidth:0] cnt_q;
  logic unused_payload;
  assign unused_payload = ^{wdata_i.data, wdata_i.strb, waddr_i.addr};
  assign entry = '{id: waddr_i.id, burst_len: waddr_i.burst_len};
  assign push = waddr_in_valid_i && !full;
  assign pop = state_q == RESP && wrsp_out_ready_i;
  assign beat = state_q == DATA && wdata_in_valid_i;
  assign final_beat = cnt_q == {1'b0, head.burst_len};
  assign waddr_in_ready_o = !full;
  assign wdata_in_ready_o = state_q == DATA;
  assign wrsp_out_valid_o = state_q == RESP;
  assign wrsp_o = state_q == RESP ? rsp : '0;
  simmem_addr_fifo #(
    .Width($bits(waddr_entry_t)),
    .Depth(AddrQueueDepth)
  ) u_addr_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    rsp = '0;
    rsp.id = head.id;
    rsp.payload[1:0] = err_q ? SLVERR : OKAY;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = DATA;
      DATA: if (beat && final_beat) state_d = RESP;
      RESP: if (wrsp_out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // burst termination is count-driven; a misplaced last only poisons the response
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !empty) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        err_q <= err_q | (wdata_i.last != final_beat) | (head.burst_len >= MaxWBurstLen);
      end
    end
endmodule

// File: doc/simmem_write_responder.md
SIMMEM_WRITE_RESPONDER -- requirements
Module: simmem_write_responder

Interface
REQ-001 SHALL have parameter AddrQueueDepth, default 4, giving the number of buffered write addresses (power of two, at least 2).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port waddr_i, input, waddr_t: write address request.
REQ-005 SHALL have port waddr_in_valid_i, input, 1 bit: waddr_i is valid.
REQ-006 SHALL have port waddr_in_ready_o, output, 1 bit: address can be accepted.
REQ-007 SHALL have port wdata_i, input, wdata_t: write data beat.
REQ-008 SHALL have port wdata_in_valid_i, input, 1 bit: wdata_i is valid.
REQ-009 SHALL have port wdata_in_ready_o, output, 1 bit: beat can be accepted.
REQ-010 SHALL have port wrsp_o, output, wresp_t: write response.
REQ-011 SHALL have port wrsp_out_valid_o, output, 1 bit: wrsp_o is valid.
REQ-012 SHALL have port wrsp_out_ready_i, input, 1 bit: downstream accepts the response.

Function
REQ-013 A transfer SHALL occur on any channel in a cycle where valid and ready are both high; ready SHALL NOT depend combinationally on the same channel's valid.
REQ-014 An address FIFO SHALL store {id, burst_len} of accepted addresses; waddr_in_ready_o = FIFO not full; no same-cycle bypass when full.
REQ-015 The FSM SHALL have three states: IDLE, DATA, RESP; reset state is IDLE.
REQ-016 IDLE -> DATA SHALL occur on the clock edge after the FIFO becomes non-empty; the beat counter clears to 0 on entry.
REQ-017 wdata_in_ready_o SHALL be 1 only in DATA; each beat handshake increments the beat counter (width AxLenWidth+1, no wrap).
REQ-018 DATA -> RESP SHALL occur on the handshake of beat number burst_len+1 (count-driven, wdata_i.last not used to terminate).
REQ-019 An error flag SHALL be set when wdata_i.last disagrees with the final-beat position on any beat, or when burst_len >= MaxWBurstLen; it clears on entry to DATA.
REQ-020 In RESP, wrsp_out_valid_o SHALL be 1, wrsp_o.id SHALL equal the head id, payload[1:0] SHALL be OKAY (0) or SLVERR (2) per the error flag, and all other payload bits SHALL be 0.
REQ-021 wrsp_o SHALL stay stable while valid is high and not yet accepted.
REQ-022 RESP -> IDLE and the FIFO head pop SHALL happen on the response handshake; a simultaneous push and pop SHALL both take effect.
REQ-023 Minimum latency SHALL be 1 cycle from the final beat handshake to wrsp_out_valid_o; each burst costs at least one IDLE bubble.
REQ-024 wdata contents and strobes SHALL be discarded (no storage).

Reset
REQ-025 While rst_ni is low: FSM = IDLE, FIFO empty, counter = 0, error flag = 0, waddr_in_ready_o = 1, wdata_in_ready_o = 0, wrsp_out_valid_o = 0, wrsp_o = 0.
REQ-026 Reset asserted mid-burst or mid-response SHALL drop all pending addresses and any partial burst with no response emitted.

Structure
REQ-027 The xresp_e enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and WRespAddrQueueDepth SHALL be added to simmem_pkg; the port types come from simmem_pkg.
REQ-028 The address FIFO SHALL be one sub-module, simmem_addr_fifo (synchronous, parameterised width and depth, full/empty outputs).

Verification
REQ-029 Address id=1, burst_len=0, one beat with last=1 -> wrsp id=1, payload=0, valid 1 cycle after the beat handshake.
REQ-030 Address id=2, burst_len=3, four beats with last only on beat 4, wrsp_out_ready_i held low 5 cycles -> wrsp stable throughout, id=2, OKAY.
REQ-031 burst_len=2 with last on beat 2 -> all three beats accepted, then SLVERR (payload=2); burst_len=5 -> SLVERR after six beats.
REQ-032 Five addresses pushed with no data -> fifth stalls (ready=0) until the first response handshake, then accepted; responses come back in id order.
REQ-033 rst_ni pulsed low during beat 2 of a 4-beat burst -> no response emitted, all outputs return to reset values, and the next transaction behaves as in REQ-029.
